// File: rtl/ahb_lite_pkg.sv
// Shared types for the two-master AHB-lite arbiter: FSM state encoding and default bus widths.
package ahb_lite_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: on a tie, the master that was not granted last wins.
module arb_rr2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant,
  output logic valid
);

  assign valid = req0 | req1;
  assign grant = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/ahb_lite_arbiter.sv
// Two-master AHB-lite style arbiter with registered bus and response outputs.
// Optional WAIT timeout abort enabled with `define ARB_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | arbitrate; latch winner's request and raise trans
// ADDR    | single address-phase cycle, trans drops at exit
// WAIT    | hold bus, wait for readyout (or timeout abort)
module ahb_lite_arbiter
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              write0,
  input  logic              write1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err,
  output logic              write,
  output logic              trans,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  input  logic              readyout,
  input  logic [DATA_W-1:0] rdata
);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              gnt_q, gnt_d;
  logic              write_q, write_d;
  logic              trans_q, trans_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              arb_grant, arb_valid;
  logic              timeout_hit;

  arb_rr2 u_arb (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Down-counter loaded in ADDR; reaching zero with readyout still low aborts.
  assign timeout_hit = (state_q == ST_WAIT) && !readyout && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    err_d = timeout_hit;
    if (state_q == ST_ADDR) begin
      cnt_d = CNT_W'(TIMEOUT - 1);
    end else if (state_q == ST_WAIT) begin
      cnt_d = (readyout || timeout_hit) ? '0 : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (arb_valid) state_d = ST_ADDR;
      ST_ADDR: state_d = ST_WAIT;
      ST_WAIT: if (readyout || timeout_hit) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    write_d      = write_q;
    trans_d      = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          gnt_d        = arb_grant;
          last_grant_d = arb_grant;
          trans_d      = 1'b1;
          write_d      = arb_grant ? write1 : write0;
          waddr_d      = arb_grant ? addr1  : addr0;
          wdata_d      = arb_grant ? wdata1 : wdata0;
        end
      end
      ST_WAIT: begin
        if (readyout) begin
          done0_d = ~gnt_q;
          done1_d = gnt_q;
          if (!write_q) begin
            if (gnt_q) rdata1_d = rdata;
            else       rdata0_d = rdata;
          end
        end
        // Bus request is released whenever the transfer ends, normally or by abort.
        if (readyout || timeout_hit) begin
          write_d = 1'b0;
          waddr_d = '0;
          wdata_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      write_q      <= 1'b0;
      trans_q      <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      write_q      <= write_d;
      trans_q      <= trans_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
    end
  end

  assign done0  = done0_q;
  assign done1  = done1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign write  = write_q;
  assign trans  = trans_q;
  assign waddr  = waddr_q;
  assign wdata  = wdata_q;

endmodule

// File: tb/tb_ahb_lite_arbiter.sv
// Directed bench for ahb_lite_arbiter: table of single-master transfers plus tie, reset, drop and WAIT-length sequences.
module tb_ahb_lite_arbiter;

  logic       clock, reset_n;
  logic       req0, req1, write0, write1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       done0, done1, err, write, trans, readyout;
  logic [7:0] rdata0, rdata1, waddr, wdata, rdata_p;

  int n_tests = 0;
  int n_fail  = 0;

  ahb_lite_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(15)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .req1(req1), .write0(write0), .write1(write1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
    .err(err), .write(write), .trans(trans), .waddr(waddr), .wdata(wdata),
    .readyout(readyout), .rdata(rdata_p)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       m;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         waits;
    logic       noise;
    logic [7:0] prdata;
    logic [7:0] exp_r0;
    logic [7:0] exp_r1;
  } vec_t;

  vec_t vecs[6];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    req0 = 0; req1 = 0; write0 = 0; write1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    readyout = 0; rdata_p = 0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic do_vec(input vec_t v);
    @(negedge clock);
    if (!v.m) begin req0 = 1; write0 = v.wr; addr0 = v.addr; wdata0 = v.wdata; end
    else      begin req1 = 1; write1 = v.wr; addr1 = v.addr; wdata1 = v.wdata; end
    readyout = v.noise;
    rdata_p  = v.prdata;
    @(negedge clock);
    chk1("v_trans_c1", trans, 1'b1);
    chk8("v_waddr", waddr, v.addr);
    chk8("v_wdata", wdata, v.wdata);
    chk1("v_write", write, v.wr);
    readyout = v.noise;
    for (int w = 0; w <= v.waits; w++) begin
      @(negedge clock);
      chk1("v_trans_wait", trans, 1'b0);
      chk1("v_done0_early", done0, 1'b0);
      chk1("v_done1_early", done1, 1'b0);
      chk8("v_waddr_hold", waddr, v.addr);
      readyout = (w == v.waits);
    end
    @(negedge clock);
    chk1("v_done0", done0, ~v.m);
    chk1("v_done1", done1, v.m);
    chk8("v_rdata0", rdata0, v.exp_r0);
    chk8("v_rdata1", rdata1, v.exp_r1);
    chk1("v_err", err, 1'b0);
    readyout = 0;
    if (!v.m) req0 = 0; else req1 = 0;
    @(negedge clock);
    chk1("v_done0_pulse", done0, 1'b0);
    chk1("v_done1_pulse", done1, 1'b0);
    chk1("v_idle_trans", trans, 1'b0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 8'h10, 8'h5A, 0, 1'b0, 8'hEE, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 8'h20, 8'h00, 0, 1'b0, 8'h33, 8'h00, 8'h33};
    vecs[2] = '{1'b0, 1'b0, 8'h30, 8'h00, 4, 1'b0, 8'hC4, 8'hC4, 8'h33};
    vecs[3] = '{1'b1, 1'b1, 8'hFF, 8'hA5, 2, 1'b1, 8'h77, 8'hC4, 8'h33};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 8'h5B, 1, 1'b1, 8'h81, 8'h81, 8'h33};
    vecs[5] = '{1'b1, 1'b0, 8'h7E, 8'h00, 3, 1'b0, 8'hFF, 8'h81, 8'hFF};

    apply_reset();
    @(negedge clock);
    chk1("rst_trans", trans, 1'b0);
    chk1("rst_write", write, 1'b0);
    chk8("rst_waddr", waddr, 8'h00);
    chk8("rst_rdata0", rdata0, 8'h00);
    chk1("rst_done0", done0, 1'b0);
    chk1("rst_err", err, 1'b0);

    foreach (vecs[i]) do_vec(vecs[i]);

    // Both masters held from reset: grants alternate 0,1,0 with one IDLE cycle between.
    apply_reset();
    req0 = 1; req1 = 1; write0 = 0; write1 = 0;
    addr0 = 8'h40; addr1 = 8'h41; readyout = 1; rdata_p = 8'h11;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clock);
      chk1("rr_trans", trans, (c % 3) == 1);
      if ((c % 3) == 1) chk8("rr_waddr", waddr, (c == 4) ? 8'h41 : 8'h40);
      chk1("rr_done0", done0, (c == 3) || (c == 9));
      chk1("rr_done1", done1, c == 6);
      if (c == 3) begin chk8("rr_rdata0_a", rdata0, 8'h11); rdata_p = 8'h22; end
      if (c == 6) begin
        chk8("rr_rdata1", rdata1, 8'h22);
        chk8("rr_rdata0_keep", rdata0, 8'h11);
        rdata_p = 8'h33;
      end
      if (c == 9) begin chk8("rr_rdata0_b", rdata0, 8'h33); chk8("rr_rdata1_keep", rdata1, 8'h22); end
    end
    req0 = 0; req1 = 0; readyout = 0;

    // Reset asserted during WAIT.
    @(negedge clock);
    req1 = 1; write1 = 1; addr1 = 8'h55; wdata1 = 8'h99;
    @(negedge clock);
    chk1("rw_trans", trans, 1'b1);
    @(negedge clock);
    chk1("rw_write_pre", write, 1'b1);
    chk8("rw_wdata_pre", wdata, 8'h99);
    #2 reset_n = 1'b0;
    #1;
    chk1("rw_write", write, 1'b0);
    chk8("rw_waddr", waddr, 8'h00);
    chk8("rw_wdata", wdata, 8'h00);
    chk1("rw_trans0", trans, 1'b0);
    chk8("rw_rdata0", rdata0, 8'h00);
    chk8("rw_rdata1", rdata1, 8'h00);
    chk1("rw_done1", done1, 1'b0);
    chk1("rw_err", err, 1'b0);
    readyout = 1;
    repeat (2) begin
      @(negedge clock);
      chk1("rw_no_done", done1, 1'b0);
    end
    reset_n = 1'b1;
    req0 = 1; write0 = 0; addr0 = 8'h66;
    write1 = 0; addr1 = 8'h67; rdata_p = 8'h5C;
    @(negedge clock);
    chk1("rw_tie_trans", trans, 1'b1);
    chk8("rw_tie_waddr", waddr, 8'h66);
    @(negedge clock);
    @(negedge clock);
    chk1("rw_tie_done0", done0, 1'b1);
    chk8("rw_tie_rdata0", rdata0, 8'h5C);
    req0 = 0; req1 = 0; readyout = 0;
    @(negedge clock);
    chk1("rw_idle", trans, 1'b0);

    // Granted request dropped in ADDR while the other master starts requesting.
    @(negedge clock);
    req0 = 1; write0 = 0; addr0 = 8'h12; rdata_p = 8'h3D;
    @(negedge clock);
    chk1("dr_trans", trans, 1'b1);
    chk8("dr_waddr", waddr, 8'h12);
    req0 = 0; req1 = 1; write1 = 0; addr1 = 8'h34;
    @(negedge clock);
    chk1("dr_trans_off", trans, 1'b0);
    chk8("dr_waddr_hold", waddr, 8'h12);
    readyout = 1;
    @(negedge clock);
    chk1("dr_done0", done0, 1'b1);
    chk1("dr_done1_q", done1, 1'b0);
    chk8("dr_rdata0", rdata0, 8'h3D);
    chk8("dr_rdata1_q", rdata1, 8'h00);
    rdata_p = 8'h4E;
    @(negedge clock);
    chk1("dr_next_trans", trans, 1'b1);
    chk8("dr_next_waddr", waddr, 8'h34);
    @(negedge clock);
    @(negedge clock);
    chk1("dr_done1", done1, 1'b1);
    chk8("dr_rdata1", rdata1, 8'h4E);
    chk8("dr_rdata0_keep", rdata0, 8'h3D);
    req1 = 0; readyout = 0;

    // readyout stuck low.
    @(negedge clock);
    req0 = 1; write0 = 0; addr0 = 8'h21; rdata_p = 8'h6A;
    @(negedge clock);
    chk1("to_trans", trans, 1'b1);
    for (int c = 2; c <= 16; c++) begin
      @(negedge clock);
      chk1("to_err_early", err, 1'b0);
      chk1("to_done_early", done0, 1'b0);
    end
`ifdef ARB_TIMEOUT_EN
    @(negedge clock);
    chk1("to_err", err, 1'b1);
    chk1("to_no_done", done0, 1'b0);
    req0 = 0; req1 = 1; write1 = 0; addr1 = 8'h43; readyout = 1;
    @(negedge clock);
    chk1("to_err_pulse", err, 1'b0);
    chk1("to_next_trans", trans, 1'b1);
    chk8("to_next_waddr", waddr, 8'h43);
    @(negedge clock);
    @(negedge clock);
    chk1("to_next_done1", done1, 1'b1);
    chk8("to_next_rdata1", rdata1, 8'h6A);
    req1 = 0; readyout = 0;
`else
    for (int c = 17; c <= 20; c++) begin
      @(negedge clock);
      chk1("nt_err", err, 1'b0);
      chk1("nt_done_early", done0, 1'b0);
      chk8("nt_waddr_hold", waddr, 8'h21);
    end
    readyout = 1;
    @(negedge clock);
    chk1("nt_done0", done0, 1'b1);
    chk8("nt_rdata0", rdata0, 8'h6A);
    req0 = 0; readyout = 0;
`endif
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
